// File: rtl/sap_pkg.sv
// Shared opcode, sequencer-state and flag-index definitions for the SAP core.
`timescale 1ns/1ps
package sap_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH0,
        S_FETCH1,
        S_EXEC0,
        S_EXEC1,
        S_EXEC2,
        S_HALT
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

endpackage

// File: rtl/sap_ram.sv
// Program/data RAM: one write port shared by the programming port and STA, combinational read.
`timescale 1ns/1ps
module sap_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_data,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // The programming port owns the write port whenever the core is held idle.
    assign wr_en   = prog_mode ? prog_we   : core_we;
    assign wr_addr = prog_mode ? prog_addr : core_addr;
    assign wr_data = prog_mode ? prog_data : core_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sap_core.sv
// Multi-cycle accumulator CPU with internal RAM, programming port and handshaked output.
// Optional single-step input enabled by defining SAP_CORE_STEP_EN.
`timescale 1ns/1ps
module sap_core
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [1:0]        flags
`ifdef SAP_CORE_STEP_EN
    ,
    input  logic              step
`endif
);

    if (DATA_W < ADDR_W + 4) begin : g_width_check
        $error("sap_core: DATA_W must be at least ADDR_W+4");
    end

    state_e            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] mar_reg, mar_next;
    logic [DATA_W-1:0] ir_reg, ir_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] b_reg, b_next;
    logic [DATA_W-1:0] out_reg, out_next;
    logic              c_reg, c_next;
    logic              z_reg, z_next;
    logic              out_valid_reg, out_valid_next;

    logic              ram_we_core;
    logic [DATA_W-1:0] ram_rdata;
    logic              advance;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] imm;
    logic              alu_sub;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W:0]   alu_sum;

`ifdef SAP_CORE_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    assign opcode  = ir_reg[DATA_W-1 -: 4];
    assign operand = ir_reg[ADDR_W-1:0];
    assign imm     = {4'b0000, ir_reg[DATA_W-5:0]};

    // Subtraction as A + ~B + 1 so the carry out doubles as "no borrow" (A >= B).
    assign alu_sub = (opcode == OP_SUB);
    assign alu_b   = alu_sub ? ~b_reg : b_reg;
    assign alu_sum = {1'b0, a_reg} + {1'b0, alu_b} + {{DATA_W{1'b0}}, alu_sub};

    sap_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .prog_mode (prog_mode),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .core_we   (ram_we_core),
        .core_addr (mar_reg),
        .core_data (a_reg),
        .raddr     (mar_reg),
        .rdata     (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH0;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        mar_next       = mar_reg;
        ir_next        = ir_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        c_next         = c_reg;
        z_next         = z_reg;
        out_next       = out_reg;
        out_valid_next = 1'b0;
        ram_we_core    = 1'b0;

        // Programming mode aborts everything but keeps A, B, flags and OUT.
        if (prog_mode) begin
            state_next = S_FETCH0;
            pc_next    = '0;
            mar_next   = '0;
            ir_next    = '0;
        end else if (advance) begin
            case (state_reg)
                S_FETCH0: begin
                    mar_next   = pc_reg;
                    state_next = S_FETCH1;
                end
                S_FETCH1: begin
                    ir_next    = ram_rdata;
                    pc_next    = pc_reg + 1'b1;
                    state_next = S_EXEC0;
                end
                S_EXEC0: begin
                    state_next = S_FETCH0;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            mar_next   = operand;
                            state_next = S_EXEC1;
                        end
                        OP_LDI: a_next = imm;
                        OP_JMP: pc_next = operand;
                        OP_JC:  if (c_reg) pc_next = operand;
                        OP_JZ:  if (z_reg) pc_next = operand;
                        OP_OUT: begin
                            out_next       = a_reg;
                            out_valid_next = 1'b1;
                        end
                        OP_HLT: state_next = S_HALT;
                        default: ;
                    endcase
                end
                S_EXEC1: begin
                    state_next = S_FETCH0;
                    case (opcode)
                        OP_LDA: a_next = ram_rdata;
                        OP_ADD, OP_SUB: begin
                            b_next     = ram_rdata;
                            state_next = S_EXEC2;
                        end
                        OP_STA: ram_we_core = 1'b1;
                        default: ;
                    endcase
                end
                S_EXEC2: begin
                    a_next     = alu_sum[DATA_W-1:0];
                    c_next     = alu_sum[DATA_W];
                    z_next     = (alu_sum[DATA_W-1:0] == '0);
                    state_next = S_FETCH0;
                end
                S_HALT:  state_next = S_HALT;
                default: state_next = S_FETCH0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg        <= '0;
            mar_reg       <= '0;
            ir_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            c_reg         <= 1'b0;
            z_reg         <= 1'b0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            mar_reg       <= mar_next;
            ir_reg        <= ir_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            c_reg         <= c_next;
            z_reg         <= z_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_data      = out_reg;
    assign out_valid     = out_valid_reg;
    assign halted        = (state_reg == S_HALT);
    assign flags[FLAG_C] = c_reg;
    assign flags[FLAG_Z] = z_reg;

endmodule

// File: tb/tb_sap_core.sv
// Directed self-checking bench for sap_core (8-bit data, 16-word RAM).
`timescale 1ns/1ps
module tb_sap_core;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              prog_mode = 1'b0;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [DATA_W-1:0] prog_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              halted;
    logic [1:0]        flags;
`ifdef SAP_CORE_STEP_EN
    logic              step = 1'b1;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [DATA_W-1:0] image [16];

    always #5 clk = ~clk;

    sap_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_mode (prog_mode),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .flags     (flags)
`ifdef SAP_CORE_STEP_EN
        ,
        .step      (step)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_image();
        for (int i = 0; i < 16; i++) image[i] = 8'h00;
    endtask

    // Leaves prog_mode high; caller releases it right after an edge.
    task automatic load_image();
        prog_mode = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            prog_we   = 1'b1;
            prog_addr = i[ADDR_W-1:0];
            prog_data = image[i];
            tick();
        end
        prog_we = 1'b0;
    endtask

    // Runs from release until halted (bounded); reports cycles, pulses and last output.
    task automatic run_until_halt(input int limit, output int cycles, output int pulses,
                                  output logic [DATA_W-1:0] last_out);
        cycles   = 0;
        pulses   = 0;
        last_out = '0;
        while (!halted && cycles < limit) begin
            tick();
            cycles++;
            if (out_valid) begin
                pulses++;
                last_out = out_data;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++; if (out_data !== 8'd0) $display("FAIL reset_out_data: got %0d want 0", out_data); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
        n_total++; if (flags !== 2'b00) $display("FAIL reset_flags: got %b want 00", flags); else n_pass++;
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_add_program();
        int pulses, pulse_cyc, halt_cyc;
        logic [DATA_W-1:0] pulse_val;
        clear_image();
        image[0] = 8'h1E; image[1] = 8'h2F; image[2] = 8'hE0; image[3] = 8'hF0;
        image[14] = 8'd28; image[15] = 8'd14;
        load_image();
        prog_mode = 1'b0;
        pulses = 0; pulse_cyc = -1; halt_cyc = -1; pulse_val = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (out_valid) begin
                pulses++;
                if (pulse_cyc < 0) pulse_cyc = c;
                pulse_val = out_data;
            end
            if (halted && halt_cyc < 0) halt_cyc = c;
        end
        n_total++; if (pulses !== 1) $display("FAIL add_pulse_count: got %0d want 1", pulses); else n_pass++;
        n_total++; if (pulse_cyc !== 12) $display("FAIL add_pulse_cycle: got %0d want 12", pulse_cyc); else n_pass++;
        n_total++; if (pulse_val !== 8'd42) $display("FAIL add_out_data: got %0d want 42", pulse_val); else n_pass++;
        n_total++; if (halt_cyc !== 15) $display("FAIL add_halt_cycle: got %0d want 15", halt_cyc); else n_pass++;
        n_total++; if (halted !== 1'b1) $display("FAIL add_halt_sticky: got %b want 1", halted); else n_pass++;
        n_total++; if (flags !== 2'b00) $display("FAIL add_flags: got %b want 00", flags); else n_pass++;
        $display("test_add_program: out=%0d at cycle %0d, halted at cycle %0d", pulse_val, pulse_cyc, halt_cyc);
    endtask

    task automatic test_sub();
        int cycles, pulses;
        logic [DATA_W-1:0] last_out;
        // 5 - 7
        clear_image();
        image[0] = 8'h55; image[1] = 8'h3F; image[2] = 8'hE0; image[3] = 8'hF0; image[15] = 8'd7;
        load_image();
        prog_mode = 1'b0;
        run_until_halt(100, cycles, pulses, last_out);
        n_total++; if (halted !== 1'b1) $display("FAIL sub1_halt: got %b want 1", halted); else n_pass++;
        n_total++; if (cycles !== 14) $display("FAIL sub1_cycles: got %0d want 14", cycles); else n_pass++;
        n_total++; if (last_out !== 8'd254) $display("FAIL sub1_result: got %0d want 254", last_out); else n_pass++;
        n_total++; if (flags !== 2'b00) $display("FAIL sub1_flags: got %b want 00", flags); else n_pass++;
        $display("test_sub 5-7: out=%0d flags=%b", last_out, flags);
        // 7 - 7
        image[0] = 8'h57;
        load_image();
        prog_mode = 1'b0;
        run_until_halt(100, cycles, pulses, last_out);
        n_total++; if (halted !== 1'b1) $display("FAIL sub2_halt: got %b want 1", halted); else n_pass++;
        n_total++; if (pulses !== 1) $display("FAIL sub2_pulses: got %0d want 1", pulses); else n_pass++;
        n_total++; if (last_out !== 8'd0) $display("FAIL sub2_result: got %0d want 0", last_out); else n_pass++;
        n_total++; if (flags !== 2'b11) $display("FAIL sub2_flags: got %b want 11", flags); else n_pass++;
        $display("test_sub 7-7: out=%0d flags=%b", last_out, flags);
    endtask

    task automatic test_loop();
        int cycles, pulses;
        logic [DATA_W-1:0] expected;
        clear_image();
        image[0] = 8'h51; image[1] = 8'h2F; image[2] = 8'hE0;
        image[3] = 8'h75; image[4] = 8'h61; image[5] = 8'hF0; image[15] = 8'd1;
        load_image();
        prog_mode = 1'b0;
        cycles = 0; pulses = 0; expected = 8'd2;
        while (!halted && cycles < 5000) begin
            tick();
            cycles++;
            if (out_valid) begin
                pulses++;
                n_total++;
                if (out_data !== expected)
                    $display("FAIL loop_out_%0d: got %0d want %0d", pulses, out_data, expected);
                else
                    n_pass++;
                expected = expected + 8'd1;
            end
        end
        n_total++; if (halted !== 1'b1) $display("FAIL loop_halt: got %b want 1 after %0d cycles", halted, cycles); else n_pass++;
        n_total++; if (pulses !== 255) $display("FAIL loop_pulse_count: got %0d want 255", pulses); else n_pass++;
        n_total++; if (flags !== 2'b11) $display("FAIL loop_flags: got %b want 11", flags); else n_pass++;
        $display("test_loop: %0d outputs in %0d cycles", pulses, cycles);
    endtask

    task automatic test_wrap();
        int pulses, first_cyc, second_cyc;
        logic [DATA_W-1:0] second_val;
        clear_image();
        image[0] = 8'h53; image[1] = 8'h6E; image[14] = 8'hE0;
        load_image();
        prog_mode = 1'b0;
        pulses = 0; first_cyc = -1; second_cyc = -1; second_val = '0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (out_valid) begin
                pulses++;
                if (pulses == 1) first_cyc = c;
                if (pulses == 2) begin
                    second_cyc = c;
                    second_val = out_data;
                end
            end
        end
        n_total++; if (first_cyc !== 9) $display("FAIL wrap_first_cycle: got %0d want 9", first_cyc); else n_pass++;
        n_total++; if (second_cyc !== 21) $display("FAIL wrap_second_cycle: got %0d want 21", second_cyc); else n_pass++;
        n_total++; if (second_val !== 8'd3) $display("FAIL wrap_second_val: got %0d want 3", second_val); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL wrap_halted: got %b want 0", halted); else n_pass++;
        $display("test_wrap: pulses at cycles %0d and %0d", first_cyc, second_cyc);
    endtask

    task automatic test_prog_abort();
        int cycles, pulses;
        logic [DATA_W-1:0] last_out;
        clear_image();
        image[0] = 8'h59; image[1] = 8'h2F; image[2] = 8'hE0; image[3] = 8'hF0; image[15] = 8'd5;
        load_image();
        prog_mode = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        // now in EXEC1 of ADD
        prog_mode = 1'b1;
        tick();
        n_total++; if (flags !== 2'b11) $display("FAIL abort_flags: got %b want 11", flags); else n_pass++;
        image[0] = 8'hE0; image[1] = 8'hF0;
        load_image();
        prog_mode = 1'b0;
        run_until_halt(50, cycles, pulses, last_out);
        n_total++; if (last_out !== 8'd9) $display("FAIL abort_a_kept: got %0d want 9", last_out); else n_pass++;
        n_total++; if (cycles !== 6) $display("FAIL abort_restart_cycles: got %0d want 6", cycles); else n_pass++;
        n_total++; if (flags !== 2'b11) $display("FAIL abort_flags_after: got %b want 11", flags); else n_pass++;
        $display("test_prog_abort: out=%0d halted after %0d cycles", last_out, cycles);
    endtask

    task automatic test_rst_during_out();
        int pulses, pulse_cyc;
        logic [DATA_W-1:0] pulse_val;
        clear_image();
        image[0] = 8'h56; image[1] = 8'hE0; image[2] = 8'hF0;
        load_image();
        prog_mode = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        // now in EXEC0 of OUT
        rst = 1'b1;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid_async: got %b want 0", out_valid); else n_pass++;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 8'd0) $display("FAIL rst_out_data: got %0d want 0", out_data); else n_pass++;
        n_total++; if (flags !== 2'b00) $display("FAIL rst_flags: got %b want 00", flags); else n_pass++;
        rst = 1'b0;
        pulses = 0; pulse_cyc = -1; pulse_val = '0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (out_valid) begin
                pulses++;
                if (pulse_cyc < 0) begin
                    pulse_cyc = c;
                    pulse_val = out_data;
                end
            end
        end
        n_total++; if (pulse_cyc !== 6) $display("FAIL rst_ram_rerun_cycle: got %0d want 6", pulse_cyc); else n_pass++;
        n_total++; if (pulse_val !== 8'd6) $display("FAIL rst_ram_intact: got %0d want 6", pulse_val); else n_pass++;
        n_total++; if (pulses !== 1) $display("FAIL rst_rerun_pulses: got %0d want 1", pulses); else n_pass++;
        $display("test_rst_during_out: rerun out=%0d at cycle %0d", pulse_val, pulse_cyc);
    endtask

`ifdef SAP_CORE_STEP_EN
    task automatic test_step();
        int pulses;
        logic [DATA_W-1:0] pulse_val;
        clear_image();
        image[0] = 8'h52; image[1] = 8'h2F; image[2] = 8'hE0; image[3] = 8'hF0; image[15] = 8'd254;
        load_image();
        step = 1'b0;
        prog_mode = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid) pulses++;
        end
        n_total++; if (pulses !== 0) $display("FAIL step_hold_pulses: got %0d want 0", pulses); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL step_hold_halted: got %b want 0", halted); else n_pass++;
        for (int p = 0; p < 3 + 4; p++) begin
            step = 1'b1; tick(); step = 1'b0; tick();
        end
        n_total++; if (flags !== 2'b00) $display("FAIL step_add_4: got %b want 00", flags); else n_pass++;
        step = 1'b1; tick(); step = 1'b0; tick();
        n_total++; if (flags !== 2'b11) $display("FAIL step_add_5: got %b want 11", flags); else n_pass++;
        pulses = 0; pulse_val = '1;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1; tick();
            if (out_valid) begin pulses++; pulse_val = out_data; end
            step = 1'b0; tick();
            if (out_valid) begin pulses++; pulse_val = out_data; end
        end
        n_total++; if (pulses !== 1) $display("FAIL step_out_pulses: got %0d want 1", pulses); else n_pass++;
        n_total++; if (pulse_val !== 8'd0) $display("FAIL step_out_val: got %0d want 0", pulse_val); else n_pass++;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1; tick(); step = 1'b0; tick();
        end
        n_total++; if (halted !== 1'b1) $display("FAIL step_halted: got %b want 1", halted); else n_pass++;
        step = 1'b1;
        $display("test_step done");
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_program();
        test_sub();
        test_loop();
        test_wrap();
        test_prog_abort();
        test_rst_during_out();
`ifdef SAP_CORE_STEP_EN
        test_step();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
